// File: rtl/vstreamout_packer_if.sv
`default_nettype none
// ============================================================================
//  Module      : vstreamout_col_if / vstreamout_axis_if
//  Description : Column-side handshake and AXI-Stream beat bus for the
//                stream-out packer.
//  Revision    : 1.0  initial release
// ============================================================================

interface vstreamout_col_if #(
   parameter int NUM_COL = 4,
   parameter int DWIDTH  = 32,
   parameter int VLEN_W  = 8
);
   logic                      is_vstreamout_global;
   logic [NUM_COL-1:0]        supplier;
   logic [NUM_COL*DWIDTH-1:0] col_data;
   logic [NUM_COL-1:0]        col_valid;
   logic [VLEN_W-1:0]         vec_len;
   logic [NUM_COL-1:0]        col_ready;
   logic [NUM_COL-1:0]        done;
   logic                      busy;

   modport master (
      output is_vstreamout_global, supplier, col_data, col_valid, vec_len,
      input  col_ready, done, busy
   );
   modport slave (
      input  is_vstreamout_global, supplier, col_data, col_valid, vec_len,
      output col_ready, done, busy
   );
endinterface

interface vstreamout_axis_if #(
   parameter int PACK   = 4,
   parameter int DWIDTH = 32
);
   logic [PACK*DWIDTH-1:0]   m_axis_tdata;
   logic [PACK*DWIDTH/8-1:0] m_axis_tkeep;
   logic                     m_axis_tvalid;
   logic                     m_axis_tlast;
   logic                     m_axis_tready;

   modport master (
      output m_axis_tdata, m_axis_tkeep, m_axis_tvalid, m_axis_tlast,
      input  m_axis_tready
   );
   modport slave (
      input  m_axis_tdata, m_axis_tkeep, m_axis_tvalid, m_axis_tlast,
      output m_axis_tready
   );
endinterface

`default_nettype wire

// File: rtl/vstreamout_packer.sv
`default_nettype none
// ============================================================================
//  Module      : vstreamout_packer
//  Description : Packs per-column stream-out words into PACK-word AXI-Stream
//                beats through a small FWFT FIFO; issues per-column done.
//  Revision    : 1.0  initial release
// ============================================================================

module vstreamout_packer #(
   parameter int NUM_COL    = 4,
   parameter int DWIDTH     = 32,
   parameter int PACK       = 4,
   parameter int FIFO_DEPTH = 8,
   parameter int VLEN_W     = 8
) (
   input  logic              clk,
   input  logic              rst,
   vstreamout_col_if.slave   col,
   vstreamout_axis_if.master axis
);

   localparam int c_lane_w = $clog2(PACK);
   localparam int c_aw     = $clog2(FIFO_DEPTH);
   localparam int c_kw     = DWIDTH / 8;
   localparam int c_ent_w  = 1 + PACK*c_kw + PACK*DWIDTH;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_STREAM  = 2'd1,
      S_HANDOFF = 2'd2,
      S_DRAIN   = 2'd3
   } state_t;

   state_t                  r_state;
   logic [VLEN_W-1:0]       r_vlen;
   logic [VLEN_W-1:0]       r_word_cnt;
   logic [c_lane_w-1:0]     r_lane;
   logic [PACK*DWIDTH-1:0]  r_pack;
   logic [NUM_COL-1:0]      r_done;

   logic [c_ent_w-1:0]      r_mem [FIFO_DEPTH];
   logic [c_aw-1:0]         r_wr_ptr;
   logic [c_aw-1:0]         r_rd_ptr;
   logic [c_aw:0]           r_count;

   logic                    w_fifo_full;
   logic                    w_fifo_empty;
   logic                    w_zero_len;
   logic                    w_streaming;
   logic                    w_accept;
   logic                    w_col_last;
   logic                    w_stream_last;
   logic                    w_push;
   logic                    w_pop;
   logic [DWIDTH-1:0]       w_word;
   logic [PACK*DWIDTH-1:0]  w_beat_data;
   logic [PACK*c_kw-1:0]    w_beat_keep;
   logic [c_ent_w-1:0]      w_head;

   assign w_fifo_full   = (r_count == (c_aw+1)'(FIFO_DEPTH));
   assign w_fifo_empty  = (r_count == '0);
   assign w_zero_len    = (r_vlen == '0);
   assign w_streaming   = (r_state == S_STREAM) && !w_zero_len;

   assign col.col_ready = (w_streaming && !w_fifo_full) ? col.supplier : '0;
   assign col.done      = r_done;
   assign col.busy      = (r_state != S_IDLE);

   assign w_accept      = |(col.col_valid & col.col_ready);
   assign w_col_last    = (r_word_cnt == r_vlen - VLEN_W'(1));
   assign w_stream_last = w_col_last && col.supplier[NUM_COL-1];
   assign w_push        = w_accept && ((r_lane == c_lane_w'(PACK-1)) || w_stream_last);
   assign w_pop         = axis.m_axis_tvalid && axis.m_axis_tready;

   always_comb begin
      w_word = '0;
      for (int i = 0; i < NUM_COL; i++) begin
         if (col.supplier[i]) w_word = w_word | col.col_data[i*DWIDTH +: DWIDTH];
      end
   end

   // Pack register holds zeros above the fill point, so a partial beat is clean
   always_comb begin
      w_beat_data = r_pack;
      w_beat_keep = '0;
      for (int l = 0; l < PACK; l++) begin
         if (c_lane_w'(l) == r_lane) w_beat_data[l*DWIDTH +: DWIDTH] = w_word;
         if (c_lane_w'(l) <= r_lane) w_beat_keep[l*c_kw +: c_kw] = '1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_vlen     <= '0;
         r_word_cnt <= '0;
         r_lane     <= '0;
         r_pack     <= '0;
         r_done     <= '0;
      end else begin
         r_done <= '0;
         case (r_state)
            S_IDLE: begin
               if (col.is_vstreamout_global) begin
                  r_vlen     <= col.vec_len;
                  r_word_cnt <= '0;
                  r_lane     <= '0;
                  r_pack     <= '0;
                  r_state    <= S_STREAM;
               end
            end
            S_STREAM: begin
               if (w_zero_len) begin
                  r_done  <= col.supplier;
                  r_state <= S_HANDOFF;
               end else if (w_accept) begin
                  r_lane <= r_lane + c_lane_w'(1);
                  r_pack <= w_push ? '0 : w_beat_data;
                  if (w_col_last) begin
                     r_word_cnt <= '0;
                     r_done     <= col.supplier;
                     r_state    <= S_HANDOFF;
                  end else begin
                     r_word_cnt <= r_word_cnt + VLEN_W'(1);
                  end
               end
            end
            S_HANDOFF: begin
               r_state <= r_done[NUM_COL-1] ? S_DRAIN : S_STREAM;
            end
            S_DRAIN: begin
               if (w_fifo_empty || ((r_count == (c_aw+1)'(1)) && w_pop)) r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= {w_stream_last, w_beat_keep, w_beat_data};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + c_aw'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + c_aw'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + (c_aw+1)'(1);
            2'b01:   r_count <= r_count - (c_aw+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // First-word fall-through head; outputs forced to zero while empty
   assign w_head             = r_mem[r_rd_ptr];
   assign axis.m_axis_tvalid = !w_fifo_empty;
   assign axis.m_axis_tdata  = w_fifo_empty ? '0 : w_head[PACK*DWIDTH-1:0];
   assign axis.m_axis_tkeep  = w_fifo_empty ? '0 : w_head[PACK*DWIDTH +: PACK*c_kw];
   assign axis.m_axis_tlast  = !w_fifo_empty && w_head[c_ent_w-1];

endmodule

`default_nettype wire

// File: tb/tb_vstreamout_packer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vstreamout_packer
//  Description : Randomized self-checking bench for vstreamout_packer against
//                a word-queue reference model.
//  Revision    : 1.0  initial release
// ============================================================================

module tb_vstreamout_packer;

   localparam int NC = 4;
   localparam int DW = 32;
   localparam int PK = 4;
   localparam int FD = 8;
   localparam int VW = 8;
   localparam int KW = PK*DW/8;
   localparam int MAXCYC = 3000;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   vstreamout_col_if  #(.NUM_COL(NC), .DWIDTH(DW), .VLEN_W(VW)) col_bus ();
   vstreamout_axis_if #(.PACK(PK), .DWIDTH(DW))                 axis_bus ();

   vstreamout_packer #(
      .NUM_COL(NC), .DWIDTH(DW), .PACK(PK), .FIFO_DEPTH(FD), .VLEN_W(VW)
   ) dut (
      .clk  (clk),
      .rst  (rst),
      .col  (col_bus),
      .axis (axis_bus)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Reference model: all words of the stream in acceptance order
   logic [DW-1:0] exp_words[$];

   function automatic void exp_beat(input int b, output logic [PK*DW-1:0] d,
                                    output logic [KW-1:0] k, output logic l);
      int n;
      int nb;
      n  = exp_words.size();
      nb = (n + PK - 1) / PK;
      d  = '0;
      k  = '0;
      for (int i = 0; i < PK; i++) begin
         if (b*PK + i < n) begin
            d[i*DW +: DW]       = exp_words[b*PK + i];
            k[i*(DW/8) +: DW/8] = '1;
         end
      end
      l = (b == nb - 1);
   endfunction

   function automatic logic [PK*DW-1:0] kmask(input logic [KW-1:0] k);
      logic [PK*DW-1:0] m;
      for (int i = 0; i < KW; i++) m[i*8 +: 8] = {8{k[i]}};
      return m;
   endfunction

   task automatic run_stream(input int vlen, input logic [NC-1:0] cols, input int vpct,
                             input int stall_len, input int rst_at);
      int               col_list[$];
      int               cur;
      int               wi;
      int               done_idx;
      int               beat_idx;
      int               nbeats;
      int               cyc;
      int               accepted;
      logic [NC-1:0]    ready_leak;
      logic [NC-1:0]    v;
      logic [NC*DW-1:0] dat;
      logic [PK*DW-1:0] ed;
      logic [KW-1:0]    ek;
      logic             el;
      logic             saw_done;

      cur = 0; wi = 0; done_idx = 0; beat_idx = 0; cyc = 0; accepted = 0;
      ready_leak = '0;
      exp_words.delete();
      for (int c = 0; c < NC; c++) begin
         if (cols[c]) begin
            col_list.push_back(c);
            for (int w = 0; w < vlen; w++) exp_words.push_back($urandom);
         end
      end
      nbeats = (exp_words.size() + PK - 1) / PK;

      @(posedge clk); #1;
      col_bus.supplier             = NC'(1) << col_list[0];
      col_bus.vec_len              = VW'(vlen);
      col_bus.is_vstreamout_global = 1'b1;
      @(posedge clk); #1;
      col_bus.is_vstreamout_global = 1'b0;
      check("busy_rise", col_bus.busy, 1);

      while (cyc < MAXCYC) begin
         saw_done = (col_bus.done != '0);
         if (saw_done) begin
            if (done_idx < col_list.size())
               check("done_onehot", col_bus.done, NC'(1) << col_list[done_idx]);
            else
               check("done_extra", col_bus.done, 0);
            done_idx++;
            if (done_idx < col_list.size()) begin
               cur = done_idx;
               wi  = 0;
            end
         end
         if (done_idx == col_list.size() && beat_idx == nbeats && !col_bus.busy) break;

         if (cyc == rst_at) begin
            rst = 1'b1;
            col_bus.col_valid       = '0;
            axis_bus.m_axis_tready  = 1'b0;
            @(posedge clk); #1;
            rst = 1'b0;
            check("rst_tvalid", axis_bus.m_axis_tvalid, 0);
            check("rst_done", col_bus.done, 0);
            check("rst_busy", col_bus.busy, 0);
            check("rst_ready", col_bus.col_ready, 0);
            return;
         end

         dat = '0;
         for (int c = 0; c < NC; c++) dat[c*DW +: DW] = $urandom;
         v = NC'($urandom);
         v[col_list[cur]] = (wi < vlen) && ($urandom_range(99) < vpct);
         if (wi < vlen) dat[col_list[cur]*DW +: DW] = exp_words[cur*vlen + wi];
         col_bus.supplier  = NC'(1) << col_list[cur];
         col_bus.col_valid = v;
         col_bus.col_data  = dat;
         axis_bus.m_axis_tready = (cyc < stall_len) ? 1'b0 : ($urandom_range(99) < 70);
         #1;

         ready_leak = ready_leak | (col_bus.col_ready & ~col_bus.supplier);
         if (saw_done) check("ready_handoff", col_bus.col_ready, 0);
         if ((col_bus.col_valid & col_bus.col_ready) != '0) begin
            accepted++;
            wi++;
         end
         if (axis_bus.m_axis_tvalid) begin
            if (beat_idx < nbeats) begin
               exp_beat(beat_idx, ed, ek, el);
               check("tdata", axis_bus.m_axis_tdata & kmask(ek), ed);
               check("tkeep", axis_bus.m_axis_tkeep, ek);
               check("tlast", axis_bus.m_axis_tlast, el);
               if (axis_bus.m_axis_tready) beat_idx++;
            end else begin
               check("extra_beat", axis_bus.m_axis_tvalid, 0);
            end
         end
         if (stall_len > 0 && cyc == stall_len - 1) begin
            check("stall_words", accepted, FD*PK);
            check("stall_ready", col_bus.col_ready, 0);
         end
         @(posedge clk); #1;
         cyc++;
      end

      check("timeout", cyc < MAXCYC, 1);
      check("beats", beat_idx, nbeats);
      check("dones", done_idx, col_list.size());
      check("words", accepted, exp_words.size());
      check("ready_leak", ready_leak, 0);
   endtask

   logic [NC-1:0] rmask;
   int            rlen;

   initial begin
      rst                          = 1'b1;
      col_bus.is_vstreamout_global = 1'b0;
      col_bus.supplier             = '0;
      col_bus.col_data             = '0;
      col_bus.col_valid            = '0;
      col_bus.vec_len              = '0;
      axis_bus.m_axis_tready       = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_tvalid", axis_bus.m_axis_tvalid, 0);
      check("reset_tdata", axis_bus.m_axis_tdata, 0);
      check("reset_tkeep", axis_bus.m_axis_tkeep, 0);
      check("reset_tlast", axis_bus.m_axis_tlast, 0);
      check("reset_done", col_bus.done, 0);
      check("reset_busy", col_bus.busy, 0);
      check("reset_ready", col_bus.col_ready, 0);
      rst = 1'b0;

      run_stream(4, 4'b1111, 100, 0, -1);
      run_stream(3, 4'b1111, 100, 0, -1);
      run_stream(5, 4'b1111, 100, 0, -1);
      run_stream(6, 4'b1111, 80, 0, -1);
      run_stream(7, 4'b1111, 80, 0, -1);
      run_stream(1, 4'b1111, 100, 0, -1);
      // three supplying columns: 6 words leave a half-filled final beat
      run_stream(2, 4'b1110, 100, 0, -1);
      run_stream(12, 4'b1111, 100, 40, -1);
      run_stream(0, 4'b1111, 100, 0, -1);
      run_stream(6, 4'b1111, 100, 0, 10);
      run_stream(5, 4'b1111, 90, 0, -1);
      for (int k = 0; k < 8; k++) begin
         rlen  = $urandom_range(9);
         rmask = NC'($urandom) | (NC'(1) << (NC-1));
         run_stream(rlen, rmask, $urandom_range(100, 50), 0, -1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
